temporal_filter_ema: RTL and testbench

Parametrised per-pixel temporal filter for the vision pipeline: maintains an exponential moving average of every pixel across successive frames in an on-chip history store, and emits the filtered pixel two cycles after input. It generalises the fixed 3×8-bit averaging filter to configurable channel count, width, frame size and smoothing strength. It adds valid qualification, first-frame seeding, flush and out-of-frame passthrough. Sits between the camera/colour-conversion stage and the object-detection stage.

---
 rtl/temporal_filter_ema.sv | 206 ++++++++++++++++++++
 tb/tb_temporal_filter_ema.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_filter_ema.sv
// temporal_filter_ema: per-pixel exponential moving average across frames.
// Each pixel keeps a fixed-point history entry in on-chip RAM.
// The filtered pixel leaves two cycles after it enters.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid, pix_in, x_in, y_in, shift_sel, flush   (input beat)
//   out_valid, pix_out, x_out, y_out                 (output beat)
//   seeding, frame_cnt                               (status)
// Option: define TF_MOTION_RESEED_EN to reseed a pixel when any channel
// moves by more than MOTION_THR from its history.
module temporal_filter_ema #(
    parameter int DATA_W     = 8,
    parameter int CHANNELS   = 3,
    parameter int COORD_W    = 11,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FRAC_W     = 4,
    parameter int MOTION_THR = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [CHANNELS*DATA_W-1:0]   pix_in,
    input  logic [COORD_W-1:0]           x_in,
    input  logic [COORD_W-1:0]           y_in,
    input  logic [2:0]                   shift_sel,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [CHANNELS*DATA_W-1:0]   pix_out,
    output logic [COORD_W-1:0]           x_out,
    output logic [COORD_W-1:0]           y_out,
    output logic                         seeding,
    output logic [15:0]                  frame_cnt
);

    localparam int PIX_W  = CHANNELS * DATA_W;
    localparam int ACC_W  = DATA_W + FRAC_W;
    localparam int MEM_W  = CHANNELS * ACC_W;
    localparam int DEPTH  = IMG_W * IMG_H;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W      = ACC_W + 2;
    localparam int HALF   = 1 << (FRAC_W - 1);
    localparam int MAXV   = (1 << DATA_W) - 1;

    // ---------------- stage 0: decode and RAM read ----------------
    logic              in_frame;
    logic              beat;
    logic              frame_start;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        shift_eff;
    logic              seed_now;
    logic              hz_now;

    // seed_pend: a seed frame is armed and begins at the next frame start
    logic              seed_pend;
    logic              in_prog;

    // stage 1 registers
    logic              s1_valid;
    logic              s1_inframe;
    logic              s1_seed;
    logic              s1_hz;
    logic [PIX_W-1:0]  s1_pix;
    logic [COORD_W-1:0] s1_x;
    logic [COORD_W-1:0] s1_y;
    logic [ADDR_W-1:0] s1_addr;
    logic [2:0]        s1_shift;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  rd_q;
    logic [MEM_W-1:0]  fwd_acc;

    assign in_frame    = (32'(x_in) < IMG_W) && (32'(y_in) < IMG_H);
    assign beat        = in_valid && in_frame;
    assign frame_start = beat && (x_in == '0) && (y_in == '0);
    assign addr        = ADDR_W'(32'(y_in) * 32'(IMG_W) + 32'(x_in));
    assign shift_eff   = (shift_sel == 3'd0) ? 3'd1 : shift_sel;

    // A frame-start beat already belongs to the frame it opens.
    assign seed_now = frame_start ? (seed_pend | flush) : seeding;

    // The RAM write of the beat now in stage 1 lands on the same edge as
    // this read, so an immediate repeat of its address must be forwarded.
    assign hz_now = beat && s1_inframe && (addr == s1_addr);

    // ---------------- stage 1: arithmetic ----------------
    logic [MEM_W-1:0]    acc_src;
    logic [MEM_W-1:0]    upd_acc;
    logic [MEM_W-1:0]    seed_acc;
    logic [MEM_W-1:0]    wr_acc;
    logic [PIX_W-1:0]    filt_pix;
    logic [PIX_W-1:0]    res_pix;
    logic [CHANNELS-1:0] mot;
    logic                reseed;
    logic                wr_en;

    assign acc_src = s1_hz ? fwd_acc : rd_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0]   in_c;
        logic [ACC_W-1:0]    acc_c;
        logic signed [W-1:0] in_s;
        logic signed [W-1:0] acc_s;
        logic signed [W-1:0] d;
        logic signed [W-1:0] an;
        logic signed [W-1:0] rnd;
        logic signed [W-1:0] o_sh;

        assign in_c  = s1_pix[c*DATA_W +: DATA_W];
        assign acc_c = acc_src[c*ACC_W +: ACC_W];
        assign in_s  = {2'b00, in_c, {FRAC_W{1'b0}}};
        assign acc_s = {2'b00, acc_c};
        assign d     = in_s - acc_s;
        assign an    = acc_s + (d >>> s1_shift);
        assign rnd   = an + W'(HALF);
        assign o_sh  = rnd >>> FRAC_W;

        assign upd_acc[c*ACC_W +: ACC_W]   = an[ACC_W-1:0];
        assign seed_acc[c*ACC_W +: ACC_W]  = {in_c, {FRAC_W{1'b0}}};
        assign filt_pix[c*DATA_W +: DATA_W] =
            (o_sh > W'(MAXV)) ? DATA_W'(MAXV) : o_sh[DATA_W-1:0];

`ifdef TF_MOTION_RESEED_EN
        logic signed [W-1:0] md;
        logic signed [W-1:0] mabs;

        assign md     = W'(in_c) - (acc_s >>> FRAC_W);
        assign mabs   = (md < 0) ? -md : md;
        assign mot[c] = mabs > W'(MOTION_THR);
`else
        assign mot[c] = 1'b0;
`endif
    end

    assign reseed  = s1_seed | (|mot);
    assign wr_acc  = reseed ? seed_acc : upd_acc;
    assign res_pix = (!s1_inframe || reseed) ? s1_pix : filt_pix;
    assign wr_en   = s1_inframe && rst;

    // History store: contents become meaningful once a seed frame passes.
    always_ff @(posedge clk) begin
        if (beat)
            rd_q <= mem[addr];
        if (wr_en)
            mem[s1_addr] <= wr_acc;
    end

    // Datapath registers carry no reset; their valids gate them.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_pix   <= pix_in;
            s1_x     <= x_in;
            s1_y     <= y_in;
            s1_addr  <= addr;
            s1_shift <= shift_eff;
        end
        if (s1_inframe)
            fwd_acc <= wr_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_inframe <= 1'b0;
            s1_seed    <= 1'b0;
            s1_hz      <= 1'b0;
            out_valid  <= 1'b0;
            pix_out    <= '0;
            x_out      <= '0;
            y_out      <= '0;
            frame_cnt  <= '0;
            seeding    <= 1'b1;
            seed_pend  <= 1'b1;
            in_prog    <= 1'b0;
        end else begin
            s1_valid   <= in_valid;
            s1_inframe <= beat;
            s1_seed    <= seed_now;
            s1_hz      <= hz_now;

            out_valid <= s1_valid;
            if (s1_valid) begin
                pix_out <= res_pix;
                x_out   <= s1_x;
                y_out   <= s1_y;
            end

            if (beat)
                in_prog <= 1'b1;
            if (frame_start) begin
                seeding   <= seed_pend | flush;
                seed_pend <= 1'b0;
                if (in_prog && frame_cnt != 16'hFFFF)
                    frame_cnt <= frame_cnt + 16'd1;
            end
            if (flush) begin
                frame_cnt <= '0;
                if (!frame_start) begin
                    seed_pend <= 1'b1;
                    in_prog   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_temporal_filter_ema.sv
// tb_temporal_filter_ema: directed plus randomized checks of the EMA filter
// against an arithmetic reference model on a 4x2 frame.
module tb_temporal_filter_ema;

    localparam int IW = 4;
    localparam int IH = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [23:0] pix_in;
    logic [10:0] x_in;
    logic [10:0] y_in;
    logic [2:0]  shift_sel;
    logic        flush;
    logic        out_valid;
    logic [23:0] pix_out;
    logic [10:0] x_out;
    logic [10:0] y_out;
    logic        seeding;
    logic [15:0] frame_cnt;

    temporal_filter_ema #(
        .DATA_W(8), .CHANNELS(3), .COORD_W(11), .IMG_W(IW), .IMG_H(IH),
        .FRAC_W(4), .MOTION_THR(48)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .pix_in(pix_in),
        .x_in(x_in), .y_in(y_in), .shift_sel(shift_sel), .flush(flush),
        .out_valid(out_valid), .pix_out(pix_out), .x_out(x_out),
        .y_out(y_out), .seeding(seeding), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [23:0] pix;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t        q[$];
    int          acc_m[IW*IH][3];
    bit          m_seed;
    bit          m_pend;
    bit          m_inprog;
    int          m_cnt;
    logic [23:0] last_pix;
    logic [10:0] last_x;
    logic [10:0] last_y;
    int          tests;
    int          fails;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: frame/seed bookkeeping plus the EMA in plain integers.
    task automatic model_beat(input bit v, input logic [23:0] p,
                              input int x, input int y, input int sh,
                              input bit fl);
        exp_t e;
        bit   fs;
        bit   sd;
        int   s;
        int   a;
        int   o;
        int   in;
        int   df;
        int   ad;
        fs = 0;
        e.v = v;
        e.pix = p;
        e.x = 11'(x);
        e.y = 11'(y);
        if (v && x < IW && y < IH) begin
            ad = y * IW + x;
            fs = (x == 0 && y == 0);
            sd = fs ? (m_pend || fl) : m_seed;
            s = (sh == 0) ? 1 : sh;
`ifdef TF_MOTION_RESEED_EN
            if (!sd)
                for (int c = 0; c < 3; c++) begin
                    df = int'(p[8*c +: 8]) - (acc_m[ad][c] / 16);
                    if (df < 0) df = -df;
                    if (df > 48) sd = 1;
                end
`endif
            for (int c = 0; c < 3; c++) begin
                in = int'(p[8*c +: 8]);
                if (sd) begin
                    acc_m[ad][c] = in * 16;
                    o = in;
                end else begin
                    a = acc_m[ad][c];
                    df = in * 16 - a;
                    a = a + (df >>> s);
                    acc_m[ad][c] = a;
                    o = (a + 8) / 16;
                    if (o > 255) o = 255;
                end
                e.pix[8*c +: 8] = 8'(o);
            end
            if (fs) begin
                if (m_inprog && m_cnt < 65535) m_cnt++;
                m_seed = m_pend || fl;
                m_pend = 0;
            end
            m_inprog = 1;
        end
        if (fl) begin
            m_cnt = 0;
            if (!fs) begin
                m_pend = 1;
                m_inprog = 0;
            end
        end
        q.push_back(e);
    endtask

    task automatic step(input bit v, input logic [23:0] p, input int x,
                        input int y, input int sh, input bit fl);
        exp_t e;
        logic [23:0] ep;
        logic [10:0] ex;
        logic [10:0] ey;
        @(negedge clk);
        rst = 1'b1;
        in_valid = v;
        pix_in = p;
        x_in = 11'(x);
        y_in = 11'(y);
        shift_sel = 3'(sh);
        flush = fl;
        model_beat(v, p, x, y, sh, fl);
        @(posedge clk);
        #1;
        e = q.pop_front();
        if (e.v) begin
            last_pix = e.pix;
            last_x = e.x;
            last_y = e.y;
        end
        ep = last_pix;
        ex = last_x;
        ey = last_y;
        chk("out_valid", 32'(out_valid), 32'(e.v));
        chk("pix_out", 32'(pix_out), 32'(ep));
        chk("x_out", 32'(x_out), 32'(ex));
        chk("y_out", 32'(y_out), 32'(ey));
        chk("seeding", 32'(seeding), 32'(m_seed));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        pix_in = 24'($urandom);
        x_in = 11'd1;
        y_in = 11'd0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pix_out", 32'(pix_out), 32'd0);
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_y_out", 32'(y_out), 32'd0);
        chk("rst_seeding", 32'(seeding), 32'd1);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        q.delete();
        e.v = 0;
        e.pix = '0;
        e.x = '0;
        e.y = '0;
        q.push_back(e);
        last_pix = '0;
        last_x = '0;
        last_y = '0;
        m_seed = 1;
        m_pend = 1;
        m_cnt = 0;
        m_inprog = 0;
    endtask

    task automatic frame(input logic [23:0] p, input int sh);
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++)
                step(1, p, x, y, sh, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        pix_in = '0;
        x_in = '0;
        y_in = '0;
        shift_sel = 3'd2;
        flush = 1'b0;

        do_reset();

        // seed frame, then convergence towards 200
        frame(24'h646464, 2);
        frame(24'hC8C8C8, 2);
        chk("ema_125", 32'(frame_cnt), 32'd1);
        frame(24'hC8C8C8, 2);
        frame(24'hC8C8C8, 2);
        step(0, 24'h0, 0, 0, 2, 0);
        chk("ema_158", 32'(pix_out), 32'h9E9E9E);
        step(0, 24'h0, 0, 0, 2, 0);

        // hazard: repeated address filters twice
        step(0, 24'h0, 0, 0, 2, 1);
        frame(24'h646464, 2);
        step(1, 24'hC8C8C8, 0, 0, 2, 0);
        step(1, 24'hC8C8C8, 1, 0, 2, 0);
        step(1, 24'hC8C8C8, 1, 0, 2, 0);
        chk("hz_first", 32'(pix_out), 32'h7D7D7D);
        step(0, 24'h0, 0, 0, 2, 0);
        chk("hz_second", 32'(pix_out), 32'h909090);

        // out-of-frame passthrough and bubbles
        step(1, 24'h123456, 7, 0, 2, 0);
        step(0, 24'hFFFFFF, 2, 0, 2, 0);
        chk("oof_pass", 32'(pix_out), 32'h123456);
        step(0, 24'hFFFFFF, 2, 0, 2, 0);
        step(1, 24'hC8C8C8, 2, 1, 0, 0);
        step(0, 24'h0, 0, 0, 2, 0);
        step(1, 24'hC8C8C8, 3, 1, 5, 0);
        step(0, 24'h0, 0, 0, 2, 0);

        // flush pulse then frame of 30
        step(0, 24'h0, 0, 0, 2, 1);
        frame(24'h1E1E1E, 2);
        step(0, 24'h0, 0, 0, 2, 0);
        chk("flush_30", 32'(pix_out), 32'h1E1E1E);

        // random frames; flush rides on a frame-start beat in frame 1
        for (int f = 0; f < 4; f++)
            for (int y = 0; y < IH; y++)
                for (int x = 0; x < IW; x++) begin
                    if ($urandom_range(3) == 0)
                        step(0, 24'($urandom), x, y, 2, 0);
                    if ($urandom_range(7) == 0)
                        step(1, 24'($urandom), $urandom_range(10, 4), y,
                             2, 0);
                    step(1, 24'($urandom), x, y, $urandom_range(7),
                         f == 1 && x == 0 && y == 0);
                    if ($urandom_range(4) == 0 && (x != 0 || y != 0))
                        step(1, 24'($urandom), x, y, $urandom_range(7), 0);
                end

        // reset in mid-frame, next frame seeds
        step(1, 24'h505050, 0, 0, 3, 0);
        step(1, 24'h505050, 1, 0, 3, 0);
        do_reset();
        for (int i = 0; i < 2 * IW * IH; i++)
            step(1, 24'($urandom), i % IW, (i / IW) % IH, 2, 0);

`ifdef TF_MOTION_RESEED_EN
        step(0, 24'h0, 0, 0, 2, 1);
        frame(24'h646464, 2);
        step(1, 24'hA0A0A0, 0, 0, 2, 0);
        step(1, 24'h8C8C8C, 1, 0, 2, 0);
        chk("mot_reseed", 32'(pix_out), 32'hA0A0A0);
        step(0, 24'h0, 0, 0, 2, 0);
        chk("mot_ema", 32'(pix_out), 32'h6E6E6E);
`endif

        step(0, 24'h0, 0, 0, 2, 0);
        step(0, 24'h0, 0, 0, 2, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
